// File: rtl/vc32_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vc32_uart_pkg                                                 |
// | Description : Shared types and constants for the vc32 console UART.        |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
package vc32_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage
`default_nettype wire

// File: rtl/vc32_uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vc32_uart_fifo                                                |
// | Description : Synchronous show-ahead FIFO; push while full is dropped.      |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module vc32_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from the registered count only, so a same-cycle pop never frees a slot for a push.
  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vc32_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vc32_uart_tx                                                  |
// | Description : 8N1 serial transmitter, LSB first, line idles high.           |
// |               VC32_UART_TX_FIFO_EN selects a FIFO_DEPTH-entry queue;        |
// |               otherwise a single holding register buffers one byte.         |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module vc32_uart_tx
  import vc32_uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic [7:0]       wdata,
  input  logic             wvalid,
  output logic             wready,
  output logic             tx,
  output logic             busy,
`ifdef VC32_UART_TX_FIFO_EN
  output logic [$clog2(FIFO_DEPTH):0] level
`else
  output logic [0:0]       level
`endif
);

  localparam int                 c_BIT_W    = $clog2(UART_DATA_BITS);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(UART_DATA_BITS - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("vc32_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_tx_state_t            r_state;
  logic [DIV_W-1:0]          r_div;
  logic [DIV_W-1:0]          r_cnt;
  logic [c_BIT_W-1:0]        r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx;
  logic                      w_have;
  logic [UART_DATA_BITS-1:0] w_head;
  logic                      w_bit_end;
  logic                      w_pop;

  assign w_bit_end = (r_cnt == '0);
  assign w_pop     = w_have && ((r_state == IDLE) || (r_state == STOP && w_bit_end));

`ifdef VC32_UART_TX_FIFO_EN
  logic w_full;
  logic w_empty;

  vc32_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (wvalid),
    .i_wdata (wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (level)
  );

  assign w_have = !w_empty;
  assign wready = !w_full;
`else
  logic                      r_hold_valid;
  logic [UART_DATA_BITS-1:0] r_hold_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end else if (wvalid && !r_hold_valid) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= wdata;
    end
  end

  assign w_have = r_hold_valid;
  assign w_head = r_hold_data;
  assign wready = !r_hold_valid;
  assign level  = r_hold_valid;
`endif

  // The divisor is latched at frame start so a mid-frame change only affects the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_div   <= div;
            r_cnt   <= div;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= r_div;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= r_div;
            if (r_bit == c_LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_div   <= div;
              r_cnt   <= div;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != IDLE) || (level != '0);

endmodule
`default_nettype wire

// File: doc/vc32_uart_tx.md
# vc32_uart_tx

Serial transmit stage of the vc32 CPU's console UART. It accepts bytes from the CPU's I/O-register write path over a valid/ready handshake and serialises them as 8N1 frames, LSB first, on the `tx` pin (`uo_out[6]`). The line idles high. An optional small FIFO decouples CPU stores from the line rate.

## Interface
Parameters:
- `DIV_W`, default 16: width of the baud divisor input.
- `FIFO_DEPTH`, default 4: entries when the FIFO is compiled in; must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `div`  in  DIV_W  bit period minus one, in clk cycles. Sampled only at frame start.
- `wdata`  in  8  byte to transmit.
- `wvalid`  in  1  write request.
- `wready`  out  1  byte accepted on an edge where `wvalid && wready`.
- `tx`  out  1  serial line, registered.
- `busy`  out  1  high while a frame is on the line or any byte is queued.
- `level`  out  $clog2(FIFO_DEPTH)+1  queued byte count; a 1-bit holding-register flag when the FIFO is compiled out.

## Operation
Reset values (asynchronous):
- `tx`=1, `busy`=0, `wready`=1, `level`=0.
- State IDLE; queue/holding register emptied.
- A reset mid-frame truncates the frame immediately; `tx` returns high with no stop bit.

State machine:
- IDLE: when a byte is queued, pop it into the shift register, load the bit counter with `div`, drive `tx`=0 and go to START.
- START: hold for div+1 cycles, then go to DATA with bit index 0.
- DATA: drive `shift[0]` for div+1 cycles per bit and shift right. After bit index 7, go to STOP.
- STOP: drive `tx`=1 for div+1 cycles. Then go to START with a new byte if one is queued (back-to-back, no idle gap), otherwise go to IDLE.

Frame and divisor rules:
- Frame = 10 bits = 10*(div+1) cycles.
- `div`=0 is legal and gives 1-cycle bits.
- A change to `div` mid-frame has no effect until the next frame start.

Handshake and queue:
- `wready` = !full, computed from registered count only. It does not depend on `wvalid`.
- A push while full is ignored. A same-cycle pop does not free the slot for that push.
- A push and a pop in the same cycle while not full leaves `level` unchanged.
- `busy` = (state != IDLE) || (level != 0).

## Timing
- Accept edge N with the engine IDLE: the byte is popped at edge N+1 and `tx` falls after edge N+1.
  - With the FIFO: pop at N+1.
  - Without the FIFO: the holding register loads at N and transfers at N+1.
- Data bit k is valid from (k+1)*(div+1) cycles after the start edge.
- The stop bit ends 10*(div+1) cycles after the start edge.
- `busy` rises after the accept edge. It falls on the edge that ends the stop bit when nothing is queued.
- `wready` falls on the edge that makes the queue full. It rises on the edge of the pop that frees a slot.

## Configuration
- Macro `VC32_UART_TX_FIFO_EN`.
- Defined: a FIFO of `FIFO_DEPTH` entries. Up to FIFO_DEPTH bytes can queue behind the frame in flight.
- Undefined: a single holding register. `wready` is low from the accept edge until the byte transfers to the shift register. At most one byte queues behind the frame in flight.
- Frame timing and the state machine are identical in both builds.

## Structure
- Package `vc32_uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS`=8;
  - `UART_FRAME_BITS`=10.
- Sub-module `vc32_uart_fifo`: a synchronous FIFO with push, pop, full, empty and count. It is instantiated only under `VC32_UART_TX_FIFO_EN`.
- The bit-period counter, bit index, shift register and FSM stay in the top module.

## Test plan
- Reset, then `div`=3, write 0x55 once:
  - `tx` low after the next edge;
  - bits 1,0,1,0,1,0,1,0 at 4-cycle spacing;
  - stop bit high;
  - `busy` falls 40 cycles after the start edge;
  - the bench receiver decodes 0x55.
- FIFO build, `div`=0, write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles:
  - `wready` drops after the 4th or 5th accept (first byte already popped);
  - frames follow with no idle gap, each exactly 10 cycles;
  - decoded stream 01 02 03 04 05.
- Non-FIFO build, write 0xA5 then hold `wvalid` with 0x3C:
  - second byte accepted only after the first transfers to the shift register;
  - `wready` low otherwise;
  - decoded A5 3C.
- Change `div` from 3 to 7 mid-frame of 0xF0:
  - current frame stays at 4-cycle bits;
  - the next queued byte 0x0F uses 8-cycle bits.
- Assert `rst_n` low during data bit 4 of 0x81:
  - `tx`=1, `busy`=0, `level`=0 immediately, before the next edge;
  - after release, write 0x7E and it is transmitted cleanly.
- Full-queue boundary, FIFO build: with `level`==FIFO_DEPTH, drive `wvalid` with 0xEE on the pop cycle:
  - the write is rejected;
  - `level` decrements by one;
  - 0xEE is never transmitted.
